// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM states, default device ID and
// the length of one SCCB phase (8 data bits plus an ACK/NA bit).
package sccb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ID,
      ID_ACK,
      SUB,
      SUB_ACK,
      WDAT,
      WDAT_ACK,
      RDAT,
      RD_NA,
      IGNORE
   } state_t;

   localparam logic [6:0] DEFAULT_DEV_ID = 7'h21;
   localparam int         PHASE_LEN      = 9;

   // Bit-counter value once all eight data bits of a phase have been clocked.
   localparam logic [3:0] LAST_DATA_BIT  = 4'(PHASE_LEN - 1);

endpackage

// File: rtl/sccb_regfile.sv
// NREGS x 8 register file: one synchronous write port, one asynchronous read
// port. Addresses outside 0..NREGS-1 are ignored on write and read as 0x00.
module sccb_regfile #(
   parameter int NREGS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data
);

   localparam int         AW    = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [8:0] LIMIT = 9'(NREGS);

   logic [7:0] mem_q [NREGS];
   logic       wr_in_range;
   logic       rd_in_range;

   assign wr_in_range = ({1'b0, wr_addr} < LIMIT);
   assign rd_in_range = ({1'b0, rd_addr} < LIMIT);

   // Register storage; cleared on reset, written when the address is implemented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (we && wr_in_range) begin
         mem_q[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = rd_in_range ? mem_q[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/sccb_responder.sv
// SCCB (3-wire-compatible, 2-wire mode) slave. Oversamples sio_c/sio_d with
// the system clock, decodes START/STOP and bit edges, and services 3-phase
// writes and 2-phase-write + 2-phase-read register accesses.
module sccb_responder
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ID = DEFAULT_DEV_ID,
   parameter int         NREGS  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sio_c,
   input  logic       sio_d_in,
   output logic       sio_d_oe,
   output logic       sio_d_out,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   localparam logic [8:0] LIMIT = 9'(NREGS);

   // Synchronizers plus one history stage for edge detection.
   logic c_s1_q, c_s2_q, c_prev_q;
   logic d_s1_q, d_s2_q, d_prev_q;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] sub_addr_q, sub_addr_d;
   logic       rw_q, rw_d;
   logic       oe_q, oe_d;
   logic       out_q, out_d;
   logic       wr_stb_q, wr_stb_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       busy_q, busy_d;

   logic       reg_we;
   logic [7:0] rd_data;
   logic       c_rise, c_fall, start_cond, stop_cond;

   // Two-flop synchronizers; reset to 1 so the bus looks idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_s1_q   <= 1'b1;
         c_s2_q   <= 1'b1;
         c_prev_q <= 1'b1;
         d_s1_q   <= 1'b1;
         d_s2_q   <= 1'b1;
         d_prev_q <= 1'b1;
      end else begin
         c_s1_q   <= sio_c;
         c_s2_q   <= c_s1_q;
         c_prev_q <= c_s2_q;
         d_s1_q   <= sio_d_in;
         d_s2_q   <= d_s1_q;
         d_prev_q <= d_s2_q;
      end
   end

   assign c_rise     =  c_s2_q & ~c_prev_q;
   assign c_fall     = ~c_s2_q &  c_prev_q;
   assign start_cond =  d_prev_q & ~d_s2_q & c_s2_q;
   assign stop_cond  = ~d_prev_q &  d_s2_q & c_s2_q;

   // FSM and datapath state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         shreg_q    <= 8'h00;
         sub_addr_q <= 8'h00;
         rw_q       <= 1'b0;
         oe_q       <= 1'b0;
         out_q      <= 1'b1;
         wr_stb_q   <= 1'b0;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         sub_addr_q <= sub_addr_d;
         rw_q       <= rw_d;
         oe_q       <= oe_d;
         out_q      <= out_d;
         wr_stb_q   <= wr_stb_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic. Data phases shift on sio_c rise; the hand-off into an
   // ACK bit happens on the fall after bit 8 so the ACK drive starts there. In
   // ACK states cnt stays at 8 on entry and drops to 0 on the ACK clock rise,
   // so the following fall is recognised as the end of the ACK bit.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      sub_addr_d = sub_addr_q;
      rw_d       = rw_q;
      oe_d       = oe_q;
      out_d      = out_q;
      wr_stb_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      reg_we     = 1'b0;

      if (stop_cond) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         out_d   = 1'b1;
         busy_d  = 1'b0;
      end else if (start_cond) begin
         state_d = ID;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         out_d   = 1'b1;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            ID, SUB, WDAT: begin
               if (c_rise && (cnt_q < LAST_DATA_BIT)) begin
                  shreg_d = {shreg_q[6:0], d_s2_q};
                  cnt_d   = cnt_q + 4'd1;
               end else if (c_fall && (cnt_q == LAST_DATA_BIT)) begin
                  oe_d  = 1'b1;
                  out_d = 1'b0;
                  if (state_q == ID) begin
                     if (shreg_q[7:1] == DEV_ID) begin
                        state_d = ID_ACK;
                        rw_d    = shreg_q[0];
                     end else begin
                        state_d = IGNORE;
                        cnt_d   = 4'd0;
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                     end
                  end else if (state_q == SUB) begin
                     state_d    = SUB_ACK;
                     sub_addr_d = shreg_q;
                  end else begin
                     state_d = WDAT_ACK;
                  end
               end
            end

            ID_ACK, SUB_ACK, WDAT_ACK: begin
               if (c_rise) begin
                  cnt_d = 4'd0;
               end else if (c_fall && (cnt_q == 4'd0)) begin
                  oe_d  = 1'b0;
                  out_d = 1'b1;
                  if (state_q == ID_ACK) begin
                     if (rw_q) begin
                        state_d = RDAT;
                        shreg_d = rd_data;
                        oe_d    = 1'b1;
                        out_d   = rd_data[7];
                     end else begin
                        state_d = SUB;
                     end
                  end else if (state_q == SUB_ACK) begin
                     state_d = WDAT;
                  end else begin
                     state_d = WDAT;
                     if ({1'b0, sub_addr_q} < LIMIT) begin
                        reg_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = sub_addr_q;
                        wr_data_d = shreg_q;
                     end
                  end
               end
            end

            RDAT: begin
               if (c_rise && (cnt_q < LAST_DATA_BIT)) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (c_fall && (cnt_q == LAST_DATA_BIT)) begin
                  state_d = RD_NA;
                  cnt_d   = 4'd0;
                  oe_d    = 1'b0;
                  out_d   = 1'b1;
               end else if (c_fall && (cnt_q != 4'd0)) begin
                  out_d   = shreg_q[6];
                  shreg_d = {shreg_q[6:0], 1'b0};
               end
            end

            RD_NA: begin
               if (c_rise) begin
                  state_d = IGNORE;
               end
            end

            IDLE, IGNORE: begin
            end

            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
               out_d   = 1'b1;
            end
         endcase
      end
   end

   sccb_regfile #(
      .NREGS (NREGS)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (reg_we),
      .wr_addr (sub_addr_q),
      .wr_data (shreg_q),
      .rd_addr (sub_addr_q),
      .rd_data (rd_data)
   );

   assign sio_d_oe  = oe_q;
   assign sio_d_out = out_q;
   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: an SCCB master model on a wired-AND bus,
// with scoreboard queues for ACKs, read data and register-write strobes.
module tb_sccb_responder;

   localparam int Q = 100;   // quarter SCCB bit period (10 clk)

   logic       clk = 1'b0;
   logic       rst;
   logic       sio_c;
   logic       master_d;
   logic       sio_d_in;
   logic       sio_d_oe;
   logic       sio_d_out;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [1:0]  exp_ack_q [$];
   logic [7:0]  exp_rd_q  [$];
   logic [15:0] exp_wr_q  [$];

   logic [15:0] obs_wr [0:63];
   int          stb_cnt = 0;
   int          oe_cnt  = 0;
   int          rd_idx  = 0;

   always #5 clk = ~clk;

   always_comb sio_d_in = master_d & (sio_d_oe ? sio_d_out : 1'b1);

   sccb_responder #(
      .DEV_ID (7'h21),
      .NREGS  (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sio_c     (sio_c),
      .sio_d_in  (sio_d_in),
      .sio_d_oe  (sio_d_oe),
      .sio_d_out (sio_d_out),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   // Record every write strobe and count cycles with the pad driven.
   always @(negedge clk) begin
      if (wr_stb) begin
         if (stb_cnt < 64) obs_wr[stb_cnt] <= {wr_addr, wr_data};
         stb_cnt <= stb_cnt + 1;
      end
      if (sio_d_oe) oe_cnt <= oe_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_cycle(input logic b, output logic rb, output logic roe);
      #Q master_d = b;
      #Q sio_c = 1'b1;
      #Q rb = sio_d_in;
      roe = sio_d_oe;
      #Q sio_c = 1'b0;
   endtask

   task automatic do_start();
      master_d = 1'b1;
      #Q sio_c = 1'b1;
      #Q master_d = 1'b0;
      #Q sio_c = 1'b0;
   endtask

   task automatic do_stop();
      #Q master_d = 1'b0;
      #Q sio_c = 1'b1;
      #Q master_d = 1'b1;
      #Q;
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      logic rb, roe;
      for (int i = 7; i > 7 - n; i--) bit_cycle(v[i], rb, roe);
   endtask

   // Send a byte and check the ACK bit: acked -> bus low and pad driven.
   task automatic send_byte(input logic [7:0] v, input logic acked, input string tag);
      logic       rb, roe;
      logic [1:0] e;
      exp_ack_q.push_back({~acked, acked});
      send_bits(v, 8);
      bit_cycle(1'b1, rb, roe);
      e = exp_ack_q.pop_front();
      chk({tag, "_ack"}, {31'd0, rb}, {31'd0, e[1]});
      chk({tag, "_ack_oe"}, {31'd0, roe}, {31'd0, e[0]});
   endtask

   task automatic read_byte(input logic [7:0] exp, input string tag);
      logic       rb, roe;
      logic       oe_all;
      logic [7:0] got;
      exp_rd_q.push_back(exp);
      oe_all = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, rb, roe);
         got[i] = rb;
         oe_all = oe_all & roe;
      end
      bit_cycle(1'b1, rb, roe);
      chk({tag, "_data"}, {24'd0, got}, {24'd0, exp_rd_q.pop_front()});
      chk({tag, "_oe"}, {31'd0, oe_all}, 32'd1);
      chk({tag, "_na_oe"}, {31'd0, roe}, 32'd0);
   endtask

   task automatic check_writes(input string tag);
      int n_obs;
      #(10 * 10);
      n_obs = stb_cnt - rd_idx;
      chk({tag, "_nstb"}, n_obs, exp_wr_q.size());
      while (rd_idx < stb_cnt && rd_idx < 64 && exp_wr_q.size() > 0) begin
         chk({tag, "_wr"}, {16'd0, obs_wr[rd_idx]}, {16'd0, exp_wr_q.pop_front()});
         rd_idx++;
      end
      rd_idx = stb_cnt;
      exp_wr_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_oe"},   {31'd0, sio_d_oe},  32'd0);
      chk({tag, "_out"},  {31'd0, sio_d_out}, 32'd1);
      chk({tag, "_stb"},  {31'd0, wr_stb},    32'd0);
      chk({tag, "_addr"}, {24'd0, wr_addr},   32'd0);
      chk({tag, "_data"}, {24'd0, wr_data},   32'd0);
      chk({tag, "_busy"}, {31'd0, busy},      32'd0);
   endtask

   initial begin
      int   oe_snap;
      logic rb, roe;

      rst      = 1'b1;
      sio_c    = 1'b1;
      master_d = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(posedge clk);

      // 3-phase write 0x42 / 0x12 / 0x80
      do_start();
      #(Q) chk("w1_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h42, 1'b1, "w1_id");
      send_byte(8'h12, 1'b1, "w1_sub");
      exp_wr_q.push_back({8'h12, 8'h80});
      send_byte(8'h80, 1'b1, "w1_dat");
      do_stop();
      check_writes("w1");
      chk("w1_busy_end", {31'd0, busy}, 32'd0);

      // Write 0xA5 to 0x05, set sub-address 0x05, then read it back
      do_start();
      send_byte(8'h42, 1'b1, "w2_id");
      send_byte(8'h05, 1'b1, "w2_sub");
      exp_wr_q.push_back({8'h05, 8'hA5});
      send_byte(8'hA5, 1'b1, "w2_dat");
      do_stop();
      check_writes("w2");
      do_start();
      send_byte(8'h42, 1'b1, "p2_id");
      send_byte(8'h05, 1'b1, "p2_sub");
      do_stop();
      do_start();
      send_byte(8'h43, 1'b1, "r2_id");
      read_byte(8'hA5, "r2");
      chk("r2_busy", {31'd0, busy}, 32'd1);
      do_stop();
      chk("r2_busy_end", {31'd0, busy}, 32'd0);
      check_writes("r2");

      // Foreign device ID 0x60: never drive, never write
      oe_snap = oe_cnt;
      do_start();
      send_byte(8'h60, 1'b0, "f_id");
      send_byte(8'h01, 1'b0, "f_sub");
      send_byte(8'h33, 1'b0, "f_dat");
      do_stop();
      chk("f_oe_cycles", oe_cnt, oe_snap);
      chk("f_busy_end", {31'd0, busy}, 32'd0);
      check_writes("f");

      // Out-of-range sub-address 0x20: ACKed, not written, reads 0x00
      do_start();
      send_byte(8'h42, 1'b1, "o_id");
      send_byte(8'h20, 1'b1, "o_sub");
      send_byte(8'h77, 1'b1, "o_dat");
      do_stop();
      check_writes("o");
      do_start();
      send_byte(8'h42, 1'b1, "o2_id");
      send_byte(8'h20, 1'b1, "o2_sub");
      do_stop();
      do_start();
      send_byte(8'h43, 1'b1, "or_id");
      read_byte(8'h00, "or");
      do_stop();

      // STOP after 4 data bits: discarded, register keeps 0xA5
      do_start();
      send_byte(8'h42, 1'b1, "pw_id");
      send_byte(8'h05, 1'b1, "pw_sub");
      send_bits(8'h3C, 4);
      do_stop();
      check_writes("pw");
      do_start();
      send_byte(8'h42, 1'b1, "pr_id");
      send_byte(8'h05, 1'b1, "pr_sub");
      do_stop();
      do_start();
      send_byte(8'h43, 1'b1, "prr_id");
      read_byte(8'hA5, "prr");
      do_stop();

      // Repeated START in the middle of the sub-address phase
      do_start();
      send_byte(8'h42, 1'b1, "rs_id0");
      send_bits(8'h07, 3);
      do_start();
      send_byte(8'h42, 1'b1, "rs_id");
      send_byte(8'h07, 1'b1, "rs_sub");
      exp_wr_q.push_back({8'h07, 8'h3C});
      send_byte(8'h3C, 1'b1, "rs_dat");
      do_stop();
      check_writes("rs");
      do_start();
      send_byte(8'h43, 1'b1, "rsr_id");
      read_byte(8'h3C, "rsr");
      do_stop();

      // Reset asserted while driving read data
      do_start();
      send_byte(8'h43, 1'b1, "mr_id");
      bit_cycle(1'b1, rb, roe);
      bit_cycle(1'b1, rb, roe);
      #Q master_d = 1'b1;
      #Q sio_c = 1'b1;
      #(Q / 2) chk("mr_pre_oe", {31'd0, sio_d_oe}, 32'd1);
      #3 rst = 1'b1;
      #1 check_reset_outputs("mr_rst");
      #50 rst = 1'b0;
      #(Q / 2) sio_c = 1'b0;
      #20 oe_snap = oe_cnt;
      for (int i = 0; i < 6; i++) bit_cycle(1'b1, rb, roe);
      chk("mr_ignore_oe", oe_cnt, oe_snap);
      chk("mr_ignore_busy", {31'd0, busy}, 32'd0);
      do_stop();
      check_writes("mr");
      do_start();
      send_byte(8'h42, 1'b1, "mr2_id");
      send_byte(8'h07, 1'b1, "mr2_sub");
      do_stop();
      do_start();
      send_byte(8'h43, 1'b1, "mr2r_id");
      read_byte(8'h00, "mr2r");
      do_stop();
      check_writes("mr2");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
